// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory and hands each fetched word to decode over valid/ready.
// A branch redirect squashes whatever is in flight; an invalid opcode or a
// misaligned branch target stops fetch until the next reset.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instr_out,
  output logic [6:0]        opcode_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              id_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              inv_op,
  output logic              halted,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_out_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic              kill;
  logic              kill_nxt;
  logic [31:0]       instr_nxt;
  logic              valid_nxt;
  logic              halted_nxt;
  logic              misalign_nxt;
  logic              tgt_misaligned;

  // The request is a pure decode of the registered state; it is forced low
  // while reset is asserted so the memory sees nothing during reset.
  assign imem_req       = rst_n & (state == ST_REQ);
  assign imem_addr      = imem_req ? pc : {ADDR_W{1'b0}};
  assign opcode_out     = instr_out[6:0];
  assign pc_inc         = pc + {{(ADDR_W-3){1'b0}}, 3'd4};
  assign tgt_misaligned = (branch_target[1:0] != 2'b00);

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      kill         <= 1'b0;
      instr_out    <= 32'h0000_0000;
      pc_out       <= {ADDR_W{1'b0}};
      instr_valid  <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      kill         <= kill_nxt;
      instr_out    <= instr_nxt;
      pc_out       <= pc_out_nxt;
      instr_valid  <= valid_nxt;
      halted       <= halted_nxt;
      misalign_err <= misalign_nxt;
    end
  end

  // Next-state and next-register logic; priority is halt on invalid opcode,
  // then misaligned-branch halt, then redirect, then the normal handshake.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    kill_nxt     = kill;
    instr_nxt    = instr_out;
    pc_out_nxt   = pc_out;
    valid_nxt    = instr_valid;
    halted_nxt   = halted;
    misalign_nxt = misalign_err;

    if (state == ST_HALT) begin
      valid_nxt  = 1'b0;
      halted_nxt = 1'b1;
    end else if (instr_valid && inv_op) begin
      state_nxt  = ST_HALT;
      valid_nxt  = 1'b0;
      halted_nxt = 1'b1;
    end else if (branch_taken && tgt_misaligned) begin
      state_nxt    = ST_HALT;
      valid_nxt    = 1'b0;
      halted_nxt   = 1'b1;
      misalign_nxt = 1'b1;
    end else if (branch_taken) begin
      pc_nxt = branch_target;
      case (state)
        ST_REQ: begin
          // The request already left this cycle; its response must be dropped.
          kill_nxt  = 1'b1;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid) begin
            kill_nxt  = 1'b0;
            state_nxt = ST_REQ;
          end else begin
            kill_nxt  = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          valid_nxt = 1'b0;
          state_nxt = ST_REQ;
        end
        default: begin
          state_nxt = ST_HALT;
        end
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid && kill) begin
            kill_nxt  = 1'b0;
            state_nxt = ST_REQ;
          end else if (imem_valid) begin
            instr_nxt  = imem_rdata;
            pc_out_nxt = pc;
            valid_nxt  = 1'b1;
            pc_nxt     = pc_inc;
            state_nxt  = ST_HOLD;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            valid_nxt = 1'b0;
            state_nxt = ST_REQ;
          end else begin
            state_nxt = ST_HOLD;
          end
        end
        default: begin
          state_nxt = ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written
// corner sequences and a randomized run compared against a behavioural model.
module tb_fetch_unit;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic          imem_valid = 1'b0;
  logic [31:0]   instr_out;
  logic [6:0]    opcode_out;
  logic [AW-1:0] pc_out;
  logic          instr_valid;
  logic          id_ready = 1'b1;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          inv_op = 1'b0;
  logic          halted;
  logic          misalign_err;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr_out(instr_out), .opcode_out(opcode_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .id_ready(id_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .inv_op(inv_op), .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (transaction view) -----------------
  logic [AW-1:0] m_pc, m_ipc;
  logic [31:0]   m_instr;
  bit m_want, m_wait, m_drop, m_show, m_halt, m_mis;

  // ---------------- memory model -----------------------------------------
  bit            mem_pend = 0;
  int            mem_cnt = 0;
  logic [AW-1:0] mem_addr = '0;
  bit            mem_fixed = 1;
  logic [31:0]   mem_data = 32'h0000_0033;
  int            lat_lo = 1, lat_hi = 1;

  function automatic logic [31:0] memfn(input logic [AW-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0033;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_ipc = '0; m_instr = 32'h0;
    m_want = 1; m_wait = 0; m_drop = 0; m_show = 0; m_halt = 0; m_mis = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit rdy,
                            input bit br, input logic [AW-1:0] tgt, input bit inv);
    if (m_halt) begin
    end else if (m_show && inv) begin
      m_halt = 1; m_show = 0;
    end else if (br && tgt[1:0] != 2'b00) begin
      m_halt = 1; m_mis = 1; m_show = 0;
    end else if (br) begin
      m_pc = tgt;
      if (m_want) begin m_want = 0; m_wait = 1; m_drop = 1; end
      else if (m_wait) begin
        if (v) begin m_wait = 0; m_drop = 0; m_want = 1; end
        else m_drop = 1;
      end else if (m_show) begin m_show = 0; m_want = 1; end
    end else begin
      if (m_want) begin m_want = 0; m_wait = 1; end
      else if (m_wait) begin
        if (v) begin
          m_wait = 0;
          if (m_drop) begin m_drop = 0; m_want = 1; end
          else begin m_show = 1; m_instr = d; m_ipc = m_pc; m_pc = m_pc + 64'd4; end
        end
      end else if (m_show && rdy) begin m_show = 0; m_want = 1; end
    end
  endtask

  // One clock: compare against the model mid-cycle, advance model and memory.
  task automatic tick();
    bit s_rst, s_req, s_v, s_rdy, s_br, s_inv, e_req;
    logic [AW-1:0] s_addr, s_tgt;
    logic [31:0] s_d;
    @(negedge clk);
    e_req = rst_n && !m_halt && m_want;
    chk("imem_req", imem_req, e_req);
    chk("imem_addr", imem_addr, e_req ? m_pc : 64'h0);
    chk("instr_valid", instr_valid, m_show);
    chk("instr_out", instr_out, m_instr);
    chk("opcode_out", opcode_out, m_instr[6:0]);
    chk("pc_out", pc_out, m_ipc);
    chk("halted", halted, m_halt);
    chk("misalign_err", misalign_err, m_mis);
    s_rst = rst_n; s_req = imem_req; s_addr = imem_addr; s_v = imem_valid;
    s_d = imem_rdata; s_rdy = id_ready; s_br = branch_taken; s_tgt = branch_target;
    s_inv = inv_op;
    @(posedge clk);
    if (s_rst) model_step(s_v, s_d, s_rdy, s_br, s_tgt, s_inv);
    else model_reset();
    if (s_req) begin
      mem_pend = 1; mem_cnt = $urandom_range(lat_hi, lat_lo); mem_addr = s_addr;
    end
    #1;
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_fixed ? mem_data : memfn(mem_addr);
        mem_pend = 0;
      end
    end
  endtask

  // Asynchronous reset pulse of one clock; optionally keeps memory in flight.
  task automatic apply_reset(input bit clear_mem);
    rst_n = 1'b0;
    model_reset();
    if (clear_mem) begin mem_pend = 0; imem_valid = 1'b0; end
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 64'h0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_pc_out", pc_out, 64'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_misalign_err", misalign_err, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int n = 0;
    while (instr_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s actual=no instr_valid required=instr_valid within %0d cycles", name, maxc);
    end
  endtask

  typedef struct {
    bit            rdy;
    bit            br;
    logic [AW-1:0] tgt;
    bit            req;
    logic [AW-1:0] addr;
    bit            vld;
    logic [AW-1:0] pco;
  } vec_t;

  function automatic vec_t mk(input bit rdy, input bit br, input logic [AW-1:0] tgt,
                              input bit req, input logic [AW-1:0] addr,
                              input bit vld, input logic [AW-1:0] pco);
    vec_t v;
    v.rdy = rdy; v.br = br; v.tgt = tgt; v.req = req; v.addr = addr; v.vld = vld; v.pco = pco;
    return v;
  endfunction

  vec_t tbl[21];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Steady stream, 5-cycle backpressure, then a branch while holding.
    tbl[0]  = mk(1, 0, 64'h0,  1, 64'h0,  0, 64'h0);
    tbl[1]  = mk(1, 0, 64'h0,  0, 64'h0,  0, 64'h0);
    tbl[2]  = mk(1, 0, 64'h0,  0, 64'h0,  1, 64'h0);
    tbl[3]  = mk(1, 0, 64'h0,  1, 64'h4,  0, 64'h0);
    tbl[4]  = mk(1, 0, 64'h0,  0, 64'h0,  0, 64'h0);
    tbl[5]  = mk(1, 0, 64'h0,  0, 64'h0,  1, 64'h4);
    tbl[6]  = mk(1, 0, 64'h0,  1, 64'h8,  0, 64'h4);
    tbl[7]  = mk(0, 0, 64'h0,  0, 64'h0,  0, 64'h4);
    tbl[8]  = mk(0, 0, 64'h0,  0, 64'h0,  1, 64'h8);
    tbl[9]  = mk(0, 0, 64'h0,  0, 64'h0,  1, 64'h8);
    tbl[10] = mk(0, 0, 64'h0,  0, 64'h0,  1, 64'h8);
    tbl[11] = mk(0, 0, 64'h0,  0, 64'h0,  1, 64'h8);
    tbl[12] = mk(0, 0, 64'h0,  0, 64'h0,  1, 64'h8);
    tbl[13] = mk(1, 0, 64'h0,  0, 64'h0,  1, 64'h8);
    tbl[14] = mk(1, 0, 64'h0,  1, 64'hC,  0, 64'h8);
    tbl[15] = mk(1, 0, 64'h0,  0, 64'h0,  0, 64'h8);
    tbl[16] = mk(1, 1, 64'h40, 0, 64'h0,  1, 64'hC);
    tbl[17] = mk(1, 0, 64'h0,  1, 64'h40, 0, 64'hC);
    tbl[18] = mk(1, 0, 64'h0,  0, 64'h0,  0, 64'hC);
    tbl[19] = mk(1, 0, 64'h0,  0, 64'h0,  1, 64'h40);
    tbl[20] = mk(1, 0, 64'h0,  1, 64'h44, 0, 64'h40);

    #2;
    mem_fixed = 1; mem_data = 32'h0000_0033; lat_lo = 1; lat_hi = 1;
    apply_reset(1);
    for (int i = 0; i < 21; i++) begin
      id_ready = tbl[i].rdy; branch_taken = tbl[i].br; branch_target = tbl[i].tgt; inv_op = 1'b0;
      #1;
      chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_pc_out", i), pc_out, tbl[i].pco);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_opcode", i), opcode_out, 7'b0110011);
        chk($sformatf("tbl%0d_instr", i), instr_out, 32'h0000_0033);
      end
      tick();
    end
    branch_taken = 1'b0; id_ready = 1'b1;

    // Branch while a response is pending: the late word must never appear.
    lat_lo = 3; lat_hi = 3; mem_data = 32'hDEAD_BEEF;
    apply_reset(1);
    tick();
    branch_taken = 1'b1; branch_target = 64'h100;
    tick();
    branch_taken = 1'b0;
    tick();
    mem_data = 32'h0000_0033; lat_lo = 1; lat_hi = 1;
    tick();
    chk("brwait_req", imem_req, 1'b1);
    chk("brwait_addr", imem_addr, 64'h100);
    wait_valid("brwait_wait", 10);
    chk("brwait_pc_out", pc_out, 64'h100);
    chk("brwait_instr", instr_out, 32'h0000_0033);

    // Invalid opcode halts; fetch stays dead until reset.
    apply_reset(1);
    wait_valid("invop_wait", 10);
    inv_op = 1'b1; id_ready = 1'b1;
    tick();
    inv_op = 1'b0;
    chk("invop_halted", halted, 1'b1);
    chk("invop_valid", instr_valid, 1'b0);
    for (int i = 0; i < 20; i++) begin
      id_ready = $urandom_range(1, 0);
      inv_op = $urandom_range(1, 0);
      branch_taken = $urandom_range(1, 0);
      branch_target = 64'h200;
      #1;
      chk("invop_noreq", imem_req, 1'b0);
      tick();
    end
    inv_op = 1'b0; branch_taken = 1'b0; id_ready = 1'b1;
    apply_reset(1);
    #1;
    chk("invop_restart_req", imem_req, 1'b1);
    chk("invop_restart_addr", imem_addr, 64'h0);

    // Misaligned branch target.
    tick();
    branch_taken = 1'b1; branch_target = 64'h102;
    tick();
    branch_taken = 1'b0;
    chk("mis_err", misalign_err, 1'b1);
    chk("mis_halted", halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("mis_noreq", imem_req, 1'b0);
      tick();
    end

    // Reset in the middle of a wait; the stale response lands after restart.
    apply_reset(1);
    lat_lo = 2; lat_hi = 2; mem_data = 32'hDEAD_BEEF;
    tick();
    apply_reset(0);
    mem_data = 32'h0000_0033;
    #1;
    chk("stale_req", imem_req, 1'b1);
    chk("stale_addr", imem_addr, 64'h0);
    wait_valid("stale_wait", 10);
    chk("stale_pc_out", pc_out, 64'h0);
    chk("stale_instr", instr_out, 32'h0000_0033);

    // Randomized run against the model.
    mem_fixed = 0; lat_lo = 1; lat_hi = 3;
    for (int ep = 0; ep < 15; ep++) begin
      apply_reset(1);
      for (int c = 0; c < 100; c++) begin
        int r;
        logic [AW-1:0] t;
        id_ready = ($urandom % 10) < 7;
        branch_taken = ($urandom % 100) < 8;
        inv_op = ($urandom % 100) < 2;
        r = $urandom % 10;
        t = {$urandom, $urandom};
        if (r == 0) t = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (($urandom % 5) != 0) t[1:0] = 2'b00;
        branch_target = t;
        if (($urandom % 150) == 0) apply_reset(0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
